// File: rtl/aes_mixcolumns_iter_if.sv
// Handshake bundle for the iterative MixColumns unit: one input channel, one
// output channel and a busy indicator.
//
// Both channels use strict valid/ready: a transfer happens on a rising edge where
// valid && ready. Once valid is raised, the sender holds it and its payload
// unchanged until that transfer happens. Ready may depend combinationally on
// the other channel, but valid never depends on ready.
interface aes_mixcolumns_iter_if;
    logic         in_valid_i;
    logic         in_ready_o;
    logic [127:0] in_data_i;
    logic         in_inv_i;
    logic         out_valid_o;
    logic         out_ready_i;
    logic [127:0] out_data_o;
    logic         busy_o;

    modport master (
        output in_valid_i, in_data_i, in_inv_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_data_o, busy_o
    );

    modport slave (
        input  in_valid_i, in_data_i, in_inv_i, out_ready_i,
        output in_ready_o, out_valid_o, out_data_o, busy_o
    );
endinterface

// File: rtl/aes_mixcolumns_iter.sv
// Iterative AES MixColumns / InvMixColumns: transforms COLS_PER_CYCLE columns per
// busy cycle, so a 128-bit state takes 4/COLS_PER_CYCLE cycles.
module aes_mixcolumns_iter #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    aes_mixcolumns_iter_if.slave bus,
    output logic [1:0]           dbg_state_o
);
    localparam int N  = 4 / COLS_PER_CYCLE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
            $error("aes_mixcolumns_iter: COLS_PER_CYCLE must be 1, 2 or 4");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    logic [127:0]   st;
    logic           inv;
    logic [CW-1:0]  cnt;
    logic [127:0]   st_mixed;
    logic           accept;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // The inverse reuses the forward network after a cheap pre-scale by {04,00}
    // on alternating rows, which factors {0e,0b,0d,09} into {02,03,01,01}.
    function automatic logic [31:0] mix_col(input logic [31:0] col, input logic inv_m);
        logic [7:0] a [4];
        logic [7:0] r [4];
        logic [7:0] t;
        logic [7:0] u;
        logic [7:0] v;
        for (int i = 0; i < 4; i++) begin
            a[i] = col[31-8*i -: 8];
        end
        u = xtime(xtime(a[0] ^ a[2]));
        v = xtime(xtime(a[1] ^ a[3]));
        if (inv_m) begin
            a[0] = a[0] ^ u;
            a[1] = a[1] ^ v;
            a[2] = a[2] ^ u;
            a[3] = a[3] ^ v;
        end
        t = a[0] ^ a[1] ^ a[2] ^ a[3];
        for (int i = 0; i < 4; i++) begin
            r[i] = a[i] ^ t ^ xtime(a[i] ^ a[(i+1)%4]);
        end
        return {r[0], r[1], r[2], r[3]};
    endfunction

    // Only COLS_PER_CYCLE column networks exist; cnt steers them across the state.
    always_comb begin
        int col_idx;
        col_idx  = 0;
        st_mixed = st;
        for (int g = 0; g < COLS_PER_CYCLE; g++) begin
            col_idx = int'(cnt) * COLS_PER_CYCLE + g;
            st_mixed[127-32*col_idx -: 32] = mix_col(st[127-32*col_idx -: 32], inv);
        end
    end

    assign bus.in_ready_o  = (state == IDLE) || ((state == DONE) && bus.out_ready_i);
    assign accept          = bus.in_valid_i && bus.in_ready_o;
    assign bus.out_valid_o = (state == DONE);
    assign bus.busy_o      = (state == BUSY);
    assign bus.out_data_o  = (state == DONE) ? st : 128'd0;
    assign dbg_state_o     = state;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state <= IDLE;
            st    <= '0;
            inv   <= 1'b0;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        st    <= bus.in_data_i;
                        inv   <= bus.in_inv_i;
                        cnt   <= '0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    st <= st_mixed;
                    if (cnt == CW'(N - 1)) begin
                        cnt   <= '0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    // Retire; a same-edge accept keeps the pipeline full.
                    if (bus.out_ready_i) begin
                        if (accept) begin
                            st    <= bus.in_data_i;
                            inv   <= bus.in_inv_i;
                            cnt   <= '0;
                            state <= BUSY;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
